// File: rtl/ahb_burst_responder_if.sv
// AHB-Lite bus bundle between the interconnect (master side) and the
// burst responder (slave side). Clock and reset stay outside the bundle.
interface ahb_burst_responder_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    // Interconnect side: drives the address/data phase and the bus-wide ready
    modport master (
        output HSEL,
        output HADDR,
        output HTRANS,
        output HWRITE,
        output HSIZE,
        output HBURST,
        output HWDATA,
        output HREADY,
        input  HRDATA,
        input  HREADYOUT,
        input  HRESP
    );

    // Responder side
    modport slave (
        input  HSEL,
        input  HADDR,
        input  HTRANS,
        input  HWRITE,
        input  HSIZE,
        input  HBURST,
        input  HWDATA,
        input  HREADY,
        output HRDATA,
        output HREADYOUT,
        output HRESP
    );
endinterface

// File: rtl/ahb_burst_responder.sv
// AHB-Lite slave backing a word-addressed register file at BASE_ADDR.
// Inserts WAIT_STATES wait cycles per OKAY data phase, answers illegal
// accesses with a two-cycle ERROR response, and tracks INCR/WRAP bursts,
// pulsing seq_err when a SEQ beat breaks the expected address sequence.
module ahb_burst_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0400,
    parameter int          DEPTH       = 64,
    parameter int          WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    ahb_burst_responder_if.slave  bus,
    output logic                  seq_err,
    output logic [4:0]            beat_cnt
);

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [31:0] WINDOW    = 32'(DEPTH * 4);
    localparam logic [2:0]  WAIT_INIT = 3'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    localparam logic [1:0]  TR_IDLE   = 2'b00;
    localparam logic [1:0]  TR_NONSEQ = 2'b10;

    localparam logic [2:0]  BU_INCR   = 3'd1;
    localparam logic [2:0]  BU_WRAP4  = 3'd2;
    localparam logic [2:0]  BU_WRAP8  = 3'd4;
    localparam logic [2:0]  BU_WRAP16 = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    // ------------------------------------------------------------------
    // Data-phase state
    // ------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [2:0]       wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             write_q, write_d;
    logic             hreadyout_q, hreadyout_d;
    logic             hresp_q, hresp_d;

    // ------------------------------------------------------------------
    // Burst tracker state
    // ------------------------------------------------------------------
    logic             open_q, open_d;
    logic             fixed_q, fixed_d;
    logic             wrap_q, wrap_d;
    logic [4:0]       len_q, len_d;
    logic [31:0]      next_addr_q, next_addr_d;
    logic [4:0]       beat_cnt_q, beat_cnt_d;
    logic             seq_err_q, seq_err_d;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]      offset;
    logic             addr_err;
    logic             accept_slot;
    logic             accept;
    logic             idle_xfer;
    logic [4:0]       hburst_len;
    logic             hburst_wrap;

    logic [31:0]      mem [DEPTH];

    // Burst length for each HBURST code; undefined-length INCR reports 0
    function automatic logic [4:0] burst_len(input logic [2:0] hburst);
        logic [4:0] len;
        case (hburst)
            3'd0:       len = 5'd1;
            3'd1:       len = 5'd0;
            3'd2, 3'd3: len = 5'd4;
            3'd4, 3'd5: len = 5'd8;
            default:    len = 5'd16;
        endcase
        return len;
    endfunction

    // Address the next SEQ beat must carry, wrapping at an L*4 byte boundary
    function automatic logic [31:0] calc_next(input logic [31:0] addr,
                                              input logic        wrap,
                                              input logic [4:0]  len);
        logic [31:0] mask;
        mask = ({27'd0, len} << 2) - 32'd1;
        if (wrap) begin
            return (addr & ~mask) | ((addr + 32'd4) & mask);
        end
        return addr + 32'd4;
    endfunction

    // Window/alignment/size check and transfer qualification for the current address phase
    always_comb begin
        offset      = bus.HADDR - BASE_ADDR;
        addr_err    = (bus.HADDR < BASE_ADDR) || (offset >= WINDOW) ||
                      (bus.HADDR[1:0] != 2'b00) || (bus.HSIZE != 3'b010);
        accept_slot = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
        accept      = accept_slot && bus.HSEL && bus.HREADY && bus.HTRANS[1];
        idle_xfer   = accept_slot && bus.HSEL && bus.HREADY && (bus.HTRANS == TR_IDLE);
        hburst_len  = burst_len(bus.HBURST);
        hburst_wrap = (bus.HBURST == BU_WRAP4) || (bus.HBURST == BU_WRAP8) ||
                      (bus.HBURST == BU_WRAP16);
    end

    // Next data-phase state and the registered HREADYOUT/HRESP it implies
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        idx_d      = idx_q;
        write_d    = write_q;
        case (state_q)
            ST_IDLE, ST_DATA, ST_ERR2: begin
                if (accept) begin
                    idx_d   = offset[IDX_W+1:2];
                    write_d = bus.HWRITE;
                    if (addr_err) begin
                        state_d = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_INIT;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 3'd0) begin
                    state_d = ST_DATA;
                end else begin
                    wait_cnt_d = wait_cnt_q - 3'd1;
                end
            end
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        hreadyout_d = !((state_d == ST_WAIT) || (state_d == ST_ERR1));
        hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
    end

    // Data-phase FSM registers, including the registered bus responses
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 3'd0;
            idx_q       <= '0;
            write_q     <= 1'b0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            idx_q       <= idx_d;
            write_q     <= write_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
        end
    end

    // Burst tracker: a mismatched SEQ beat still advances along the expected
    // sequence so that later correct beats of the same burst are not flagged
    always_comb begin
        open_d      = open_q;
        fixed_d     = fixed_q;
        wrap_d      = wrap_q;
        len_d       = len_q;
        next_addr_d = next_addr_q;
        beat_cnt_d  = beat_cnt_q;
        seq_err_d   = 1'b0;
        if (accept) begin
            if (bus.HTRANS == TR_NONSEQ) begin
                if (open_q && fixed_q && (beat_cnt_q < len_q)) begin
                    seq_err_d = 1'b1;
                end
                open_d      = 1'b1;
                fixed_d     = (bus.HBURST != BU_INCR);
                wrap_d      = hburst_wrap;
                len_d       = hburst_len;
                beat_cnt_d  = 5'd1;
                next_addr_d = calc_next(bus.HADDR, hburst_wrap, hburst_len);
            end else begin
                if (!open_q) begin
                    seq_err_d = 1'b1;
                end else if (fixed_q && (beat_cnt_q >= len_q)) begin
                    seq_err_d = 1'b1;
                end else begin
                    if (bus.HADDR != next_addr_q) begin
                        seq_err_d = 1'b1;
                    end
                    beat_cnt_d  = (beat_cnt_q == 5'd31) ? 5'd31 : (beat_cnt_q + 5'd1);
                    next_addr_d = calc_next(next_addr_q, wrap_q, len_q);
                end
            end
        end else if (idle_xfer) begin
            open_d     = 1'b0;
            beat_cnt_d = 5'd0;
        end
    end

    // Burst tracker registers
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            open_q      <= 1'b0;
            fixed_q     <= 1'b0;
            wrap_q      <= 1'b0;
            len_q       <= 5'd0;
            next_addr_q <= 32'd0;
            beat_cnt_q  <= 5'd0;
            seq_err_q   <= 1'b0;
        end else begin
            open_q      <= open_d;
            fixed_q     <= fixed_d;
            wrap_q      <= wrap_d;
            len_q       <= len_d;
            next_addr_q <= next_addr_d;
            beat_cnt_q  <= beat_cnt_d;
            seq_err_q   <= seq_err_d;
        end
    end

    // Register file write; only a write DATA cycle commits, so errored or
    // reset-aborted transfers leave the memory untouched
    always_ff @(posedge HCLK) begin
        if ((state_q == ST_DATA) && write_q) begin
            mem[idx_q] <= bus.HWDATA;
        end
    end

    // Read data is only driven during a read DATA cycle
    always_comb begin
        if ((state_q == ST_DATA) && !write_q) begin
            bus.HRDATA = mem[idx_q];
        end else begin
            bus.HRDATA = 32'd0;
        end
    end

    assign bus.HREADYOUT = hreadyout_q;
    assign bus.HRESP     = hresp_q;
    assign seq_err       = seq_err_q;
    assign beat_cnt      = beat_cnt_q;

endmodule

// File: tb/tb_ahb_burst_responder.sv
// Self-checking bench for ahb_burst_responder: one instance with zero wait
// states and one with three, sharing a master driver and a scoreboard.
module tb_ahb_burst_responder;

    localparam logic [31:0] BASE = 32'h8000_0400;
    localparam logic [1:0]  NONSEQ = 2'b10;
    localparam logic [1:0]  SEQ    = 2'b11;
    localparam logic [2:0]  B_SINGLE = 3'd0;
    localparam logic [2:0]  B_INCR   = 3'd1;
    localparam logic [2:0]  B_INCR4  = 3'd3;
    localparam logic [2:0]  B_WRAP8  = 3'd4;
    localparam logic [2:0]  WORD     = 3'b010;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic        exp_seq;
        int          exp_beat;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        chk;
        logic        resp;
        int          waits;
        logic        seq;
        int          beat;
        logic        write;
        int          key;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    int          sel;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;

    logic        seq0, seq1;
    logic [4:0]  beat0, beat1;
    logic        obs_ready, obs_resp, obs_seq;
    logic [31:0] obs_rdata;
    logic [4:0]  obs_beat;

    beat_t       stim[$];
    exp_t        sb[$];
    logic [31:0] model[int];
    int          checks = 0;
    int          errors = 0;
    int          seq_pulses;

    always #5 clk = ~clk;

    ahb_burst_responder_if bus0();
    ahb_burst_responder_if bus1();

    assign bus0.HSEL   = hsel && (sel == 0);
    assign bus1.HSEL   = hsel && (sel == 1);
    assign bus0.HADDR  = haddr;   assign bus1.HADDR  = haddr;
    assign bus0.HTRANS = htrans;  assign bus1.HTRANS = htrans;
    assign bus0.HWRITE = hwrite;  assign bus1.HWRITE = hwrite;
    assign bus0.HSIZE  = hsize;   assign bus1.HSIZE  = hsize;
    assign bus0.HBURST = hburst;  assign bus1.HBURST = hburst;
    assign bus0.HWDATA = hwdata;  assign bus1.HWDATA = hwdata;
    assign bus0.HREADY = bus0.HREADYOUT;
    assign bus1.HREADY = bus1.HREADYOUT;

    assign obs_ready = (sel == 1) ? bus1.HREADYOUT : bus0.HREADYOUT;
    assign obs_resp  = (sel == 1) ? bus1.HRESP     : bus0.HRESP;
    assign obs_rdata = (sel == 1) ? bus1.HRDATA    : bus0.HRDATA;
    assign obs_seq   = (sel == 1) ? seq1           : seq0;
    assign obs_beat  = (sel == 1) ? beat1          : beat0;

    ahb_burst_responder #(.BASE_ADDR(BASE), .DEPTH(64), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRESETn(rst_n), .bus(bus0), .seq_err(seq0), .beat_cnt(beat0)
    );

    ahb_burst_responder #(.BASE_ADDR(BASE), .DEPTH(64), .WAIT_STATES(3)) dut1 (
        .HCLK(clk), .HRESETn(rst_n), .bus(bus1), .seq_err(seq1), .beat_cnt(beat1)
    );

    task automatic add_beat(input logic [31:0] addr, input logic [1:0] trans,
                            input logic [2:0] burst, input logic write,
                            input logic [2:0] size, input logic [31:0] wdata,
                            input logic exp_seq, input int exp_beat);
        beat_t b;
        b.addr = addr; b.trans = trans; b.burst = burst; b.write = write;
        b.size = size; b.wdata = wdata; b.exp_seq = exp_seq; b.exp_beat = exp_beat;
        stim.push_back(b);
    endtask

    // Pipelined master: runs the queued beats, pushing expectations on address
    // acceptance and comparing them as each data phase unfolds. Entered and
    // left 1 time unit after a rising edge; ends with an IDLE transfer.
    task automatic run_stim(input string tag);
        int    ai = 0;
        int    low = 0;
        int    guard = 0;
        bit    first = 0;
        bit    err;
        exp_t  e;
        beat_t b;
        seq_pulses = 0;
        sb.delete();
        while ((ai < stim.size() || sb.size() > 0) && guard < 400) begin
            if (ai < stim.size()) begin
                hsel = 1'b1; haddr = stim[ai].addr; htrans = stim[ai].trans;
                hwrite = stim[ai].write; hsize = stim[ai].size; hburst = stim[ai].burst;
            end else begin
                hsel = 1'b1; haddr = BASE; htrans = 2'b00;
                hwrite = 1'b0; hsize = WORD; hburst = B_SINGLE;
            end
            hwdata = (sb.size() > 0) ? sb[0].wdata : 32'h0;
            @(negedge clk);
            if (obs_seq === 1'b1) seq_pulses++;
            if (sb.size() > 0) begin
                e = sb[0];
                if (first) begin
                    checks++;
                    if (obs_seq !== e.seq) begin
                        errors++;
                        $display("[TB] FAIL %s seq_err @%h: got %b, want %b", tag, e.addr, obs_seq, e.seq);
                    end
                    if (e.beat >= 0) begin
                        checks++;
                        if (obs_beat !== 5'(e.beat)) begin
                            errors++;
                            $display("[TB] FAIL %s beat_cnt @%h: got %0d, want %0d", tag, e.addr, obs_beat, e.beat);
                        end
                    end
                    first = 0;
                end
                if (obs_ready !== 1'b1) begin
                    low++;
                    checks++;
                    if (obs_resp !== e.resp || obs_rdata !== 32'h0) begin
                        errors++;
                        $display("[TB] FAIL %s stall cycle @%h: HRESP=%b HRDATA=%h, want HRESP=%b HRDATA=0",
                                 tag, e.addr, obs_resp, obs_rdata, e.resp);
                    end
                end else begin
                    checks++;
                    if (low != e.waits) begin
                        errors++;
                        $display("[TB] FAIL %s stall count @%h: got %0d, want %0d", tag, e.addr, low, e.waits);
                    end
                    checks++;
                    if (obs_resp !== e.resp) begin
                        errors++;
                        $display("[TB] FAIL %s HRESP @%h: got %b, want %b", tag, e.addr, obs_resp, e.resp);
                    end
                    if (e.chk) begin
                        checks++;
                        if (obs_rdata !== e.rdata) begin
                            errors++;
                            $display("[TB] FAIL %s HRDATA @%h: got %h, want %h", tag, e.addr, obs_rdata, e.rdata);
                        end
                    end
                    if (e.write && !e.resp) model[e.key] = e.wdata;
                    e = sb.pop_front();
                    low = 0;
                end
            end
            if (obs_ready === 1'b1 && ai < stim.size()) begin
                b = stim[ai];
                err = (b.addr < BASE) || ((b.addr - BASE) >= 32'd256) ||
                      (b.addr[1:0] != 2'b00) || (b.size != WORD);
                e.addr  = b.addr;
                e.wdata = b.wdata;
                e.resp  = err;
                e.waits = err ? 1 : ((sel == 1) ? 3 : 0);
                e.seq   = b.exp_seq;
                e.beat  = b.exp_beat;
                e.write = b.write;
                e.key   = sel * 256 + int'((b.addr - BASE) >> 2);
                if (b.write || err) begin
                    e.chk = 1'b1; e.rdata = 32'h0;
                end else if (model.exists(e.key)) begin
                    e.chk = 1'b1; e.rdata = model[e.key];
                end else begin
                    e.chk = 1'b0; e.rdata = 32'h0;
                end
                sb.push_back(e);
                first = 1;
                ai++;
            end
            guard++;
            @(posedge clk); #1;
        end
        if (guard >= 400) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: %0d beats left", tag, sb.size());
        end
        hsel = 1'b0; htrans = 2'b00;
        stim.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hsel = 1'b0; haddr = BASE; htrans = 2'b00; hwrite = 1'b0;
        hsize = WORD; hburst = B_SINGLE; hwdata = 32'h0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            checks++;
            if (obs_ready !== 1'b1 || obs_resp !== 1'b0 || obs_rdata !== 32'h0 ||
                obs_seq !== 1'b0 || obs_beat !== 5'd0) begin
                errors++;
                $display("[TB] FAIL reset dut%0d: rdy=%b resp=%b rdata=%h seq=%b beat=%0d, want 1 0 0 0 0",
                         s, obs_ready, obs_resp, obs_rdata, obs_seq, obs_beat);
            end
        end
        sel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_rw();
        sel = 0;
        add_beat(BASE, NONSEQ, B_SINGLE, 1'b1, WORD, 32'hDEAD_BEEF, 1'b0, -1);
        add_beat(BASE, NONSEQ, B_SINGLE, 1'b0, WORD, 32'h0, 1'b0, -1);
        run_stim("single_rw");
    endtask

    task automatic test_incr4();
        sel = 0;
        for (int i = 0; i < 4; i++)
            add_beat(BASE + 32'h10 + 32'(4 * i), (i == 0) ? NONSEQ : SEQ, B_INCR4, 1'b1, WORD,
                     32'(i + 1), 1'b0, i + 1);
        for (int i = 0; i < 4; i++)
            add_beat(BASE + 32'h10 + 32'(4 * i), (i == 0) ? NONSEQ : SEQ, B_INCR4, 1'b0, WORD,
                     32'h0, 1'b0, i + 1);
        run_stim("incr4");
        checks++;
        if (seq_pulses != 0) begin
            errors++;
            $display("[TB] FAIL incr4 seq_err cycles: got %0d, want 0", seq_pulses);
        end
    endtask

    task automatic test_wrap8();
        int off[8] = '{'h18, 'h1C, 'h00, 'h04, 'h08, 'h0C, 'h10, 'h14};
        sel = 0;
        for (int i = 0; i < 8; i++)
            add_beat(BASE + 32'(off[i]), (i == 0) ? NONSEQ : SEQ, B_WRAP8, 1'b1, WORD,
                     32'hA500_0000 + 32'(off[i]), 1'b0, i + 1);
        run_stim("wrap8");
        checks++;
        if (seq_pulses != 0) begin
            errors++;
            $display("[TB] FAIL wrap8 seq_err cycles: got %0d, want 0", seq_pulses);
        end
        add_beat(BASE + 32'h18, NONSEQ, B_WRAP8, 1'b0, WORD, 32'h0, 1'b0, 1);
        add_beat(BASE + 32'h1C, SEQ, B_WRAP8, 1'b0, WORD, 32'h0, 1'b0, 2);
        add_beat(BASE + 32'h20, SEQ, B_WRAP8, 1'b0, WORD, 32'h0, 1'b1, -1);
        run_stim("wrap8_bad");
        checks++;
        if (seq_pulses != 1) begin
            errors++;
            $display("[TB] FAIL wrap8_bad seq_err cycles: got %0d, want 1", seq_pulses);
        end
    endtask

    task automatic test_seq_violations();
        sel = 0;
        add_beat(BASE + 32'h40, SEQ, B_INCR, 1'b1, WORD, 32'h0000_0440, 1'b1, -1);
        run_stim("seq_no_burst");
        add_beat(BASE + 32'h40, NONSEQ, B_INCR4, 1'b1, WORD, 32'h0000_0441, 1'b0, 1);
        add_beat(BASE + 32'h44, SEQ, B_INCR4, 1'b1, WORD, 32'h0000_0444, 1'b0, 2);
        add_beat(BASE + 32'h50, NONSEQ, B_SINGLE, 1'b1, WORD, 32'h0000_0450, 1'b1, -1);
        run_stim("nonseq_early");
        for (int i = 0; i < 5; i++)
            add_beat(BASE + 32'h60 + 32'(4 * i), (i == 0) ? NONSEQ : SEQ, B_INCR4, 1'b0, WORD,
                     32'h0, (i == 4) ? 1'b1 : 1'b0, (i < 4) ? i + 1 : -1);
        run_stim("seq_overrun");
        for (int i = 0; i < 33; i++)
            add_beat(BASE + 32'(4 * i), (i == 0) ? NONSEQ : SEQ, B_INCR, 1'b0, WORD,
                     32'h0, 1'b0, (i < 31) ? i + 1 : 31);
        run_stim("incr_saturate");
    endtask

    task automatic test_errors();
        sel = 0;
        add_beat(BASE + 32'h100, NONSEQ, B_SINGLE, 1'b1, WORD, 32'h1234_5678, 1'b0, -1);
        add_beat(BASE, NONSEQ, B_SINGLE, 1'b1, 3'b001, 32'h0BAD_BAD0, 1'b0, -1);
        add_beat(BASE, NONSEQ, B_SINGLE, 1'b0, WORD, 32'h0, 1'b0, -1);
        add_beat(BASE + 32'h2, NONSEQ, B_SINGLE, 1'b0, WORD, 32'h0, 1'b0, -1);
        add_beat(BASE - 32'h4, NONSEQ, B_SINGLE, 1'b0, WORD, 32'h0, 1'b0, -1);
        add_beat(BASE + 32'hFC, NONSEQ, B_SINGLE, 1'b1, WORD, 32'h5A5A_A5A5, 1'b0, -1);
        add_beat(BASE + 32'hFC, NONSEQ, B_SINGLE, 1'b0, WORD, 32'h0, 1'b0, -1);
        run_stim("errors");
    endtask

    task automatic test_wait_states();
        sel = 1;
        add_beat(BASE + 32'h30, NONSEQ, B_SINGLE, 1'b1, WORD, 32'hCAFE_F00D, 1'b0, -1);
        add_beat(BASE + 32'h30, NONSEQ, B_SINGLE, 1'b0, WORD, 32'h0, 1'b0, -1);
        add_beat(BASE + 32'h100, NONSEQ, B_SINGLE, 1'b0, WORD, 32'h0, 1'b0, -1);
        add_beat(BASE + 32'h30, NONSEQ, B_SINGLE, 1'b0, WORD, 32'h0, 1'b0, -1);
        run_stim("wait_states");
    endtask

    task automatic test_reset_midwrite();
        sel = 1;
        add_beat(BASE + 32'h40, NONSEQ, B_SINGLE, 1'b1, WORD, 32'h1111_1111, 1'b0, -1);
        run_stim("reset_pre");
        hsel = 1'b1; haddr = BASE + 32'h40; htrans = NONSEQ; hwrite = 1'b1;
        hsize = WORD; hburst = B_SINGLE;
        @(posedge clk); #1;
        htrans = 2'b00; hwdata = 32'h2222_2222;
        @(negedge clk);
        checks++;
        if (obs_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid wait entry: HREADYOUT=%b, want 0", obs_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_ready !== 1'b1 || obs_resp !== 1'b0 || obs_beat !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid outputs: rdy=%b resp=%b beat=%0d, want 1 0 0",
                     obs_ready, obs_resp, obs_beat);
        end
        hsel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        add_beat(BASE + 32'h40, NONSEQ, B_SINGLE, 1'b0, WORD, 32'h0, 1'b0, -1);
        run_stim("reset_post");
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_single_rw();
        test_incr4();
        test_wrap8();
        test_seq_violations();
        test_errors();
        test_wait_states();
        test_reset_midwrite();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
